// File: rtl/vga_pkg.sv
// Shared constants for the text-mode display path.
// Holds the screen geometry, glyph size, pixel latency, memory address
// widths and the text-buffer cell address helper.
package vga_pkg;
  localparam int COLS    = 80;
  localparam int ROWS    = 30;
  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;
  localparam int LAT     = 3;
  localparam int TB_AW   = 12;
  localparam int FONT_AW = 11;
  localparam int ROW_W   = $clog2(CHAR_H);

  // Linear text-buffer address of a cell; 29*80+79 fits easily in 12 bits.
  function automatic logic [TB_AW-1:0] cell_addr(input logic [4:0] row,
                                                 input logic [6:0] col,
                                                 input int         cols);
    return TB_AW'(row) * TB_AW'(cols) + TB_AW'(col);
  endfunction
endpackage

// File: rtl/font_fetch_ctrl_if.sv
// Host font-read port of font_fetch_ctrl.
//   hreq_i   host request, held until hgnt_o
//   haddr_i  font ROM address to read
//   hgnt_o   request accepted this cycle
//   hvalid_o hdata_o valid (one cycle, the cycle after the grant)
//   hdata_o  font ROM data returned to the host
// master = host side, slave = font_fetch_ctrl side.
interface font_fetch_ctrl_if;
  import vga_pkg::*;
  logic               hreq_i;
  logic [FONT_AW-1:0] haddr_i;
  logic               hgnt_o;
  logic               hvalid_o;
  logic [7:0]         hdata_o;

  modport master (output hreq_i, haddr_i, input  hgnt_o, hvalid_o, hdata_o);
  modport slave  (input  hreq_i, haddr_i, output hgnt_o, hvalid_o, hdata_o);
endinterface

// File: rtl/pixel_shifter.sv
// Glyph row serializer: loads an 8-bit glyph row and emits it LSB first,
// one bit per clock, for 8 clocks.
//   clk_i, rst_i    clock, async active-high reset
//   load_i, data_i  load a new glyph row (wins over shifting)
//   pixel_o         current pixel, 0 when nothing is pending
//   pixel_valid_o   a loaded bit is being shown
module pixel_shifter
  import vga_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [CHAR_W-1:0] data_i,
  output logic              pixel_o,
  output logic              pixel_valid_o
);
  localparam int CW = $clog2(CHAR_W + 1);

  logic [CHAR_W-1:0] sr_q;
  logic [CW-1:0]     cnt_q;

  // A load on the cycle the last bit is out keeps adjacent cells gapless.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= CW'(CHAR_W);
    end else if (cnt_q != '0) begin
      sr_q  <= sr_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign pixel_valid_o = (cnt_q != '0);
  assign pixel_o       = pixel_valid_o & sr_q[0];
endmodule

// File: rtl/font_fetch_ctrl.sv
// Text-mode character fetch: at each cell start C it addresses the text
// buffer, in C+1 (F) it addresses the font ROM with {char, glyph row}, in
// C+2 it loads the glyph into the shifter, so pixels leave LAT=3 clocks
// after their hpos. The font ROM port is shared with a host reader that
// is granted on every non-F cycle.
//   clk_i, rst_i            clock, async active-high reset
//   hpos_i, vpos_i, active_i raster position and visible flag
//   tb_addr_o / tb_data_i   text buffer (1-clock read latency)
//   font_addr_o/font_data_i font ROM (1-clock read latency)
//   host                    host font-read port (slave modport)
//   pixel_o, pixel_valid_o  serialized pixel and its qualifier
module font_fetch_ctrl
  import vga_pkg::TB_AW, vga_pkg::FONT_AW, vga_pkg::ROW_W, vga_pkg::cell_addr;
#(
  parameter int COLS = vga_pkg::COLS,
  parameter int ROWS = vga_pkg::ROWS,
  parameter int LAT  = vga_pkg::LAT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [9:0]         hpos_i,
  input  logic [9:0]         vpos_i,
  input  logic               active_i,
  output logic [TB_AW-1:0]   tb_addr_o,
  input  logic [7:0]         tb_data_i,
  output logic [FONT_AW-1:0] font_addr_o,
  input  logic [7:0]         font_data_i,
  font_fetch_ctrl_if.slave   host,
  output logic               pixel_o,
  output logic               pixel_valid_o
);
  // LAT is set by the two 1-clock RAM reads plus the shifter load;
  // stage 1 is the font fetch cycle, stage STAGES is the glyph load.
  localparam int STAGES = LAT - 1;

  logic [6:0]         col;
  logic [4:0]         row;
  logic               cell_start;
  logic [STAGES:1]    vld_pipe;
  logic               f_cyc;
  logic               load;
  logic [ROW_W-1:0]   glyph_row_q;
  logic [TB_AW-1:0]   tb_addr_q;
  logic [FONT_AW-1:0] font_addr_q;
  logic               hvalid_q;
  logic               unused_bits;

  assign col = hpos_i[9:3];
  assign row = vpos_i[8:4];

  // Gated by reset so nothing is addressed or granted while held in reset.
  assign cell_start = !rst_i && active_i && (hpos_i[2:0] == 3'd0) &&
                      (int'(col) < COLS) && (int'(row) < ROWS);

  assign f_cyc = vld_pipe[1];
  assign load  = vld_pipe[STAGES];

  assign host.hgnt_o = !rst_i && host.hreq_i && !f_cyc;

  // Addresses go out combinationally so each RAM samples them at the end
  // of the same cycle; otherwise they hold their last value.
  always_comb begin
    tb_addr_o = tb_addr_q;
    if (cell_start) tb_addr_o = cell_addr(row, col, COLS);
    font_addr_o = font_addr_q;
    if (f_cyc)              font_addr_o = {tb_data_i[6:0], glyph_row_q};
    else if (host.hgnt_o)   font_addr_o = host.haddr_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe    <= '0;
      glyph_row_q <= '0;
      tb_addr_q   <= '0;
      font_addr_q <= '0;
      hvalid_q    <= 1'b0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], cell_start};
      if (cell_start) glyph_row_q <= vpos_i[ROW_W-1:0];
      tb_addr_q   <= tb_addr_o;
      font_addr_q <= font_addr_o;
      hvalid_q    <= host.hgnt_o;
    end
  end

  // ROM data for a grant arrives the next cycle; pass it straight through.
  assign host.hvalid_o = hvalid_q;
  assign host.hdata_o  = hvalid_q ? font_data_i : 8'h00;

  pixel_shifter u_shift (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load),
    .data_i       (font_data_i),
    .pixel_o      (pixel_o),
    .pixel_valid_o(pixel_valid_o)
  );

  // ASCII bit 7 and vpos bit 9 have no role here.
  assign unused_bits = tb_data_i[7] ^ vpos_i[9];
endmodule

// File: tb/tb_font_fetch_ctrl.sv
module tb_font_fetch_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [9:0]  hpos_i = '0, vpos_i = '0;
  logic        active_i = 1'b0;
  logic [11:0] tb_addr_o;
  logic [7:0]  tb_data_i;
  logic [10:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic        pixel_o, pixel_valid_o;

  font_fetch_ctrl_if hif();

  font_fetch_ctrl #(.COLS(80), .ROWS(30), .LAT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hpos_i(hpos_i), .vpos_i(vpos_i),
    .active_i(active_i), .tb_addr_o(tb_addr_o), .tb_data_i(tb_data_i),
    .font_addr_o(font_addr_o), .font_data_i(font_data_i), .host(hif),
    .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Text buffer and font ROM: synchronous, 1-clock read latency.
  logic [7:0] tbmem   [0:4095];
  logic [7:0] fontmem [0:2047];
  always @(posedge clk_i) begin
    tb_data_i   <= tbmem[tb_addr_o];
    font_data_i <= fontmem[font_addr_o];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int a, input int h, input int v, input int rq, input int ha);
    @(negedge clk_i);
    active_i    = 1'(a);
    hpos_i      = 10'(h);
    vpos_i      = 10'(v);
    hif.hreq_i  = 1'(rq);
    hif.haddr_i = 11'(ha);
    #1;
  endtask

  typedef struct {
    logic        act;
    logic [9:0]  h;
    logic        rq;
    logic [10:0] ha;
    logic [11:0] e_tb;
    logic [10:0] e_fa;
    logic        e_gnt, e_hv;
    logic [7:0]  e_hd;
    logic        e_pix, e_pv;
  } vec_t;

  function automatic vec_t mkv(int a, int h, int rq, int ha, int etb, int efa,
                               int g, int hv, int hd, int px, int pv);
    vec_t v;
    v.act = 1'(a);  v.h = 10'(h);  v.rq = 1'(rq);  v.ha = 11'(ha);
    v.e_tb = 12'(etb); v.e_fa = 11'(efa); v.e_gnt = 1'(g); v.e_hv = 1'(hv);
    v.e_hd = 8'(hd); v.e_pix = 1'(px); v.e_pv = 1'(pv);
    return v;
  endfunction

  vec_t vt [13];

  initial begin
    int nvalid, vbad, pbad, bad;
    logic [7:0]  ch, g;
    logic [10:0] fa;

    for (int a = 0; a < 4096; a++) tbmem[a] = 8'h80 | 8'(a & 'h7F);
    for (int a = 0; a < 2048; a++) fontmem[a] = 8'(a) ^ 8'h5A;
    tbmem[0]          = 8'h41;
    fontmem[11'h415]  = 8'h3C;

    // Cell at row 0 col 0, vpos 5; host request lands in F then C+2.
    vt[0]  = mkv(0, 0, 0, 0,     0, 0,     0, 0, 0,    0, 0);
    vt[1]  = mkv(1, 0, 0, 0,     0, 0,     0, 0, 0,    0, 0);
    vt[2]  = mkv(1, 1, 1, 'h123, 0, 'h415, 0, 0, 0,    0, 0);
    vt[3]  = mkv(1, 2, 1, 'h123, 0, 'h123, 1, 0, 0,    0, 0);
    vt[4]  = mkv(0, 3, 0, 0,     0, 'h123, 0, 1, 'h79, 0, 1);
    vt[5]  = mkv(0, 4, 0, 0,     0, 'h123, 0, 0, 0,    0, 1);
    vt[6]  = mkv(0, 5, 0, 0,     0, 'h123, 0, 0, 0,    1, 1);
    vt[7]  = mkv(0, 6, 0, 0,     0, 'h123, 0, 0, 0,    1, 1);
    vt[8]  = mkv(0, 7, 0, 0,     0, 'h123, 0, 0, 0,    1, 1);
    vt[9]  = mkv(0, 8, 0, 0,     0, 'h123, 0, 0, 0,    1, 1);
    vt[10] = mkv(0, 9, 0, 0,     0, 'h123, 0, 0, 0,    0, 1);
    vt[11] = mkv(0, 10, 0, 0,    0, 'h123, 0, 0, 0,    0, 1);
    vt[12] = mkv(0, 11, 0, 0,    0, 'h123, 0, 0, 0,    0, 0);

    // Reset state, with cell-start and host request stimulus present.
    drive(1, 0, 5, 1, 'h155);
    drive(1, 0, 5, 1, 'h155);
    chk("reset_outputs", 64'({tb_addr_o, font_addr_o, hif.hgnt_o, hif.hvalid_o,
                              hif.hdata_o, pixel_o, pixel_valid_o}), 64'(0));
    drive(0, 0, 5, 0, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].act, vt[i].h, 5, vt[i].rq, vt[i].ha);
      chk($sformatf("vec%0d", i),
          64'({tb_addr_o, font_addr_o, hif.hgnt_o, hif.hvalid_o,
               (vt[i].e_hv ? hif.hdata_o : 8'h00), pixel_o, pixel_valid_o}),
          64'({vt[i].e_tb, vt[i].e_fa, vt[i].e_gnt, vt[i].e_hv, vt[i].e_hd,
               vt[i].e_pix, vt[i].e_pv}));
    end

    // Full line at vpos 479 (row 29, glyph row 15).
    nvalid = 0; vbad = 0; pbad = 0;
    for (int h = 0; h < 806; h++) begin
      drive(h < 640 ? 1 : 0, h, 479, 0, 0);
      if (h < 640 && h % 8 == 0)
        chk("line_tb_addr", 64'(tb_addr_o), 64'(2320 + h / 8));
      if (pixel_valid_o === 1'b1) nvalid++;
      if (pixel_valid_o !== ((h >= 3 && h < 643) ? 1'b1 : 1'b0)) vbad++;
      if (h >= 3 && h < 643) begin
        ch = tbmem[2320 + (h - 3) / 8];
        fa = {ch[6:0], 4'hF};
        g  = fontmem[fa];
        if (pixel_o !== g[(h - 3) % 8]) pbad++;
      end
    end
    chk("line_valid_cycles", 64'(nvalid), 64'(640));
    chk("line_valid_gaps", 64'(vbad), 64'(0));
    chk("line_pixels", 64'(pbad), 64'(0));

    // Host burst during blanking: a grant every cycle, data the next.
    for (int i = 0; i <= 16; i++) begin
      drive(0, 700, 479, i < 16 ? 1 : 0, i < 16 ? i : 0);
      if (i < 16) chk("burst_gnt", 64'({hif.hgnt_o, font_addr_o}), 64'({1'b1, 11'(i)}));
      if (i >= 1) chk("burst_data", 64'({hif.hvalid_o, hif.hdata_o}),
                      64'({1'b1, fontmem[i - 1]}));
    end

    // Reset pulsed at C+5 with a host read in flight.
    drive(1, 0, 5, 0, 0);          // C
    drive(0, 1, 5, 0, 0);
    drive(0, 2, 5, 0, 0);
    drive(0, 3, 5, 0, 0);
    drive(0, 4, 5, 1, 'h200);      // C+4: grant
    drive(0, 5, 5, 0, 0);          // C+5
    chk("pre_reset_state", 64'({pixel_valid_o, hif.hvalid_o}), 64'(2'b11));
    rst_i = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({tb_addr_o, font_addr_o, hif.hgnt_o, hif.hvalid_o,
                                    hif.hdata_o, pixel_o, pixel_valid_o}), 64'(0));
    drive(0, 6, 5, 0, 0);
    rst_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 7, 5, 0, 0);
      if (pixel_valid_o !== 1'b0 || hif.hvalid_o !== 1'b0) bad++;
    end
    chk("post_reset_quiet", 64'(bad), 64'(0));
    drive(1, 8, 5, 0, 0);          // C' at col 1
    chk("post_reset_tb_addr", 64'(tb_addr_o), 64'(1));
    drive(0, 9, 5, 0, 0);
    drive(0, 10, 5, 0, 0);         // C'+2
    chk("post_reset_c2", 64'(pixel_valid_o), 64'(0));
    drive(0, 11, 5, 0, 0);         // C'+3: glyph 0x4F, bit0 = 1
    chk("post_reset_c3", 64'({pixel_valid_o, pixel_o}), 64'(2'b11));

    // Out-of-range column and row start nothing.
    for (int i = 0; i < 10; i++) drive(0, 12, 5, 0, 0);
    drive(1, 640, 5, 0, 0);
    chk("col80_tb_addr", 64'(tb_addr_o), 64'(1));
    drive(1, 0, 480, 0, 0);
    chk("row30_tb_addr", 64'(tb_addr_o), 64'(1));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 480, 0, 0);
      if (pixel_valid_o !== 1'b0) bad++;
    end
    chk("oob_no_pixels", 64'(bad), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
